branch_target_buffer: RTL

- Parametrised, direct-mapped branch target buffer with 2-bit saturating direction predictors.
- Sits beside the PC register and instruction memory in IF: the fetch PC is looked up the same cycle and the block supplies a predicted next PC for taken branches and jumps.
- EXE reports resolved branches and jumps back through the update port; the block also flags mispredictions so the hazard logic can flush if_id/id_exe.

---
 rtl/btb_pkg.sv | 31 +++
 rtl/branch_target_buffer_if.sv | 33 +++
 rtl/sat_counter2.sv | 34 +++
 rtl/branch_target_buffer.sv | 109 ++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared constants and index/tag helpers for the branch target buffer
// Contents:
//   ctr_state_e  2-bit direction counter states SNT/WNT/WT/ST
//   CTR_RESET    counter value after reset (WNT)
//   CTR_ALLOC    counter value written on allocation (WT)
//   btb_index    low idx_w bits of a PC (entry index)
//   btb_tag      remaining pc_w-idx_w bits of a PC (entry tag)
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  localparam logic [1:0] CTR_RESET = WNT;
  localparam logic [1:0] CTR_ALLOC = WT;

  // Helpers work on a 32-bit container; callers size-cast the result to IDX_W/TAG_W.
  function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_w);
    return pc & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int pc_w, input int idx_w);
    logic [31:0] pc_m;
    pc_m = (pc_w >= 32) ? pc : (pc & ((32'd1 << pc_w) - 32'd1));
    return pc_m >> idx_w;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and EXE update bundle of the branch target buffer
// Signals:
//   lookup_pc, pred_hit, pred_taken, pred_target            IF-stage lookup
//   upd_valid, upd_pc, upd_taken, upd_target,
//   upd_pred_taken, upd_pred_target, mispredict             EXE-stage resolve/update
//   inv_all                                                 clear all valid bits
// Modports: master (pipeline side), slave (the buffer).
interface branch_target_buffer_if #(parameter int PC_W = 16);
  logic [PC_W-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_pred_taken;
  logic [PC_W-1:0] upd_pred_target;
  logic            mispredict;
  logic            inv_all;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, inv_all,
    input  pred_hit, pred_taken, pred_target, mispredict
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, inv_all,
    output pred_hit, pred_taken, pred_target, mispredict
  );
endinterface

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down direction counter with enable and load
// Ports:
//   clk, rst   clock, asynchronous active-high reset (to WNT)
//   en         advance this cycle
//   load       when en: take load_val instead of counting
//   up         when en & !load: 1 = increment, 0 = decrement (both saturating)
//   load_val   value loaded on allocation
//   ctr        current state
module sat_counter2
  import btb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic       up,
  input  logic [1:0] load_val,
  output logic [1:0] ctr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= CTR_RESET;
    end else if (en) begin
      if (load)
        ctr <= load_val;
      else if (up)
        ctr <= (ctr == ST) ? ctr : ctr + 2'd1;
      else
        ctr <= (ctr == SNT) ? ctr : ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with per-entry 2-bit direction counters
// Parameters: PC_W (PC/target width), DEPTH (entries, power of two 2..256)
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        branch_target_buffer_if.slave: lookup, update, mispredict, inv_all
// Optional (macro BTB_STATS_EN):
//   stat_clr                                        synchronous clear of statistics
//   stat_lookups, stat_hits, stat_mispredicts       32-bit saturating event counters
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  branch_target_buffer_if.slave bus
`ifdef BTB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = PC_W - IDX_W;

  // Flop storage: lookup is asynchronous and reset must clear every valid bit.
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag    [DEPTH];
  logic [PC_W-1:0]  target [DEPTH];
  logic [1:0]       ctr    [DEPTH];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic             we;

  assign l_idx = IDX_W'(btb_index(32'(bus.lookup_pc), IDX_W));
  assign l_tag = TAG_W'(btb_tag(32'(bus.lookup_pc), PC_W, IDX_W));
  assign u_idx = IDX_W'(btb_index(32'(bus.upd_pc), IDX_W));
  assign u_tag = TAG_W'(btb_tag(32'(bus.upd_pc), PC_W, IDX_W));

  assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

  // inv_all wins over a same-cycle update: nothing is written.
  assign we = bus.upd_valid && !bus.inv_all;

  assign bus.pred_hit    = l_hit;
  assign bus.pred_taken  = l_hit && ctr[l_idx][1];
  assign bus.pred_target = l_hit ? target[l_idx] : '0;

  assign bus.mispredict = bus.upd_valid &&
                          ((bus.upd_taken != bus.upd_pred_taken) ||
                           (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (bus.inv_all) begin
      valid <= '0;
    end else if (we && bus.upd_taken) begin
      // Taken resolves always refresh the target; a miss also claims the slot.
      target[u_idx] <= bus.upd_target;
      if (!u_hit) begin
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
      end
    end
  end

  // Counter steps on a hit, or loads WT when a taken miss allocates.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk      (clk),
      .rst      (rst),
      .en       (we && (u_idx == IDX_W'(g)) && (u_hit || bus.upd_taken)),
      .load     (!u_hit),
      .up       (bus.upd_taken),
      .load_val (CTR_ALLOC),
      .ctr      (ctr[g])
    );
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst || stat_clr) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (stat_lookups != '1)
        stat_lookups <= stat_lookups + 32'd1;
      if (l_hit && (stat_hits != '1))
        stat_hits <= stat_hits + 32'd1;
      if (bus.mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
